// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// The feeder state encoding lives here so the top and any debug logic agree on it.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {FD_IDLE, FD_LOAD, FD_REQ, FD_BUSY} feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Single-clock FIFO with occupancy count; full/empty are decoded from the count.
// The head word is read combinationally so the consumer can pop and capture in one cycle.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wrEn,
  input  logic [DATA_WIDTH-1:0]   wrData,
  input  logic                    rdEn,
  output logic [DATA_WIDTH-1:0]   rdData,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  w_do_wr;
  logic                  w_do_rd;

  assign full    = (r_count == FULL_COUNT);
  assign empty   = (r_count == '0);
  assign w_do_wr = wrEn & ~full;
  assign w_do_rd = rdEn & ~empty;
  assign rdData  = r_mem[r_rd_ptr];
  assign count   = r_count;

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= wrData;
    end
  end

  // Pointers are exactly log2(DEPTH) wide, so they wrap without compare logic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte queue and start handshake in front of the UART transmitter.
// Words are popped into txMessage and offered on txStart, paced by the synchronised idle.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = UART_DATA_WIDTH,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   inData,
  input  logic                    inValid,
  output logic                    inReady,
  output logic [DATA_WIDTH-1:0]   txMessage,
  output logic                    txStart,
  input  logic                    txIdle,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  feeder_state_t          r_state;
  feeder_state_t          w_state_next;
  logic [SYNC_STAGES-1:0] r_idle_sync;
  logic                   w_idle_s;
  logic [DATA_WIDTH-1:0]  r_tx_message;
  logic                   r_overflow;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [DATA_WIDTH-1:0]  w_fifo_head;

  // Ready is decoded from registered occupancy only: a pop in the same cycle never frees a slot.
  assign inReady   = ~w_fifo_full;
  assign w_push    = inValid & ~w_fifo_full;
  assign w_idle_s  = r_idle_sync[SYNC_STAGES-1];
  assign txStart   = (r_state == FD_REQ);
  assign txMessage = r_tx_message;
  assign overflow  = r_overflow;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrEn   (w_push),
    .wrData (inData),
    .rdEn   (w_pop),
    .rdData (w_fifo_head),
    .count  (count),
    .full   (w_fifo_full),
    .empty  (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idle_sync <= '1;
    end else begin
      r_idle_sync[0] <= txIdle;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_idle_sync[i] <= r_idle_sync[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= FD_IDLE;
      r_tx_message <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) r_tx_message <= w_fifo_head;
      if (inValid && w_fifo_full) r_overflow <= 1'b1;
    end
  end

  // Waiting for idle to fall in REQ guarantees the transmitter latched the word before txStart drops.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      FD_IDLE: if (!w_fifo_empty && w_idle_s) w_state_next = FD_LOAD;
      FD_LOAD: begin
        w_pop        = 1'b1;
        w_state_next = FD_REQ;
      end
      FD_REQ:  if (!w_idle_s) w_state_next = FD_BUSY;
      FD_BUSY: if (w_idle_s) w_state_next = FD_IDLE;
      default: w_state_next = FD_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder with a behavioural UART transmitter on the far side.
// Expected frames come from a queue of accepted words; occupancy from simple push/pop arithmetic.
`timescale 1ns/1ps
module tb_uart_tx_feeder;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int SYNC  = 2;
  localparam int DIV   = 5;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [DW-1:0]          inData = '0;
  logic                   inValid = 1'b0;
  logic                   inReady;
  logic [DW-1:0]          txMessage;
  logic                   txStart;
  logic                   txIdle;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inData    (inData),
    .inValid   (inValid),
    .inReady   (inReady),
    .txMessage (txMessage),
    .txStart   (txStart),
    .txIdle    (txIdle),
    .count     (count),
    .overflow  (overflow)
  );

  // Transmitter model: one bit per DIV clocks, samples txStart only when idle on a bit tick.
  int            tick_cnt = 0;
  logic          tx_busy = 1'b0;
  logic          stall = 1'b0;
  logic          txd = 1'b1;
  logic [3:0]    bit_idx = '0;
  logic [DW-1:0] tx_word = '0;
  logic [DW-1:0] frames[$];
  logic          bit_log[$];
  int            stable_viol = 0;
  int            start_cycles = 0;

  assign txIdle = ~tx_busy & ~stall;

  always @(posedge clk) begin
    if (txStart) start_cycles <= start_cycles + 1;
    tick_cnt <= (tick_cnt == DIV-1) ? 0 : tick_cnt + 1;
    if (tick_cnt == DIV-1) begin
      if (!tx_busy) begin
        if (txStart && !stall) begin
          tx_busy <= 1'b1;
          tx_word <= txMessage;
          bit_idx <= '0;
          txd     <= 1'b0;
          frames.push_back(txMessage);
        end
      end else begin
        bit_log.push_back(txd);
        if (txMessage !== tx_word) stable_viol <= stable_viol + 1;
        if (bit_idx == 4'(DW+1)) begin
          tx_busy <= 1'b0;
          txd     <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 1'b1;
          txd     <= (bit_idx < 4'(DW)) ? tx_word[bit_idx[2:0]] : 1'b1;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    inValid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_frames(input int n, output bit ok);
    int budget;
    budget = n * 100 + 200;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frames.size() >= n && !tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    inValid = 1'b1;
    inData = 8'h3C;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady: got %b expected 1", inReady); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (txStart !== 1'b0) begin errors++; $display("FAIL reset_txStart: got %b expected 0", txStart); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (txMessage !== '0) begin errors++; $display("FAIL reset_txMessage: got %h expected 00", txMessage); end
    rst_n = 1'b1;
    inValid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (count !== '0 || txStart !== 1'b0) begin errors++; $display("FAIL reset_no_word: got count=%0d txStart=%b expected 0/0", count, txStart); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic exp_bits[$];
    logic [DW-1:0] w;
    bit ok;
    w = 8'hA5;
    do_reset();
    frames.delete();
    bit_log.delete();
    repeat (2) @(negedge clk);
    inData = w;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    $display("push %h", w);
    @(negedge clk);
    checks++; if (txStart !== 1'b0) begin errors++; $display("FAIL single_start_early: got %b expected 0", txStart); end
    @(negedge clk);
    checks++; if (txStart !== 1'b1) begin errors++; $display("FAIL single_start_latency: got %b expected 1", txStart); end
    checks++; if (txMessage !== w) begin errors++; $display("FAIL single_txMessage: got %h expected %h", txMessage, w); end
    checks++; if (count !== '0) begin errors++; $display("FAIL single_count: got %0d expected 0", count); end
    wait_frames(1, ok);
    repeat (150) @(negedge clk);
    checks++; if (!ok || frames.size() != 1) begin errors++; $display("FAIL single_frames: got %0d frames expected 1", frames.size()); end
    exp_bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_bits.push_back(w[i]);
    exp_bits.push_back(1'b1);
    checks++; if (bit_log.size() != exp_bits.size()) begin errors++; $display("FAIL single_bitcount: got %0d expected %0d", bit_log.size(), exp_bits.size()); end
    for (int i = 0; i < exp_bits.size() && i < bit_log.size(); i++) begin
      checks++; if (bit_log[i] !== exp_bits[i]) begin errors++; $display("FAIL single_txd_bit%0d: got %b expected %b", i, bit_log[i], exp_bits[i]); end
    end
    $display("frame %h sent", (frames.size() > 0) ? frames[0] : 8'h00);
  endtask

  task automatic test_burst();
    int peak;
    int viol0;
    bit ok;
    do_reset();
    frames.delete();
    repeat (2) @(negedge clk);
    viol0 = stable_viol;
    peak = 0;
    for (int i = 1; i <= 5; i++) begin
      inData = 8'(i);
      inValid = 1'b1;
      @(negedge clk);
      $display("push %h", 8'(i));
      if (int'(count) > peak) peak = int'(count);
    end
    inValid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (int'(count) > peak) peak = int'(count);
    end
    checks++; if (peak < 4 || peak > 5) begin errors++; $display("FAIL burst_peak: got %0d expected 4..5", peak); end
    wait_frames(5, ok);
    repeat (150) @(negedge clk);
    checks++; if (!ok || frames.size() != 5) begin errors++; $display("FAIL burst_frames: got %0d expected 5", frames.size()); end
    for (int i = 0; i < frames.size() && i < 5; i++) begin
      checks++; if (frames[i] !== 8'(i+1)) begin errors++; $display("FAIL burst_order%0d: got %h expected %h", i, frames[i], 8'(i+1)); end
      $display("frame %h sent", frames[i]);
    end
    checks++; if (stable_viol != viol0) begin errors++; $display("FAIL burst_stable: got %0d changes expected 0", stable_viol - viol0); end
    checks++; if (count !== '0) begin errors++; $display("FAIL burst_count_end: got %0d expected 0", count); end
  endtask

  task automatic test_random_stream();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] w;
    int n;
    int viol0;
    bit ok;
    do_reset();
    frames.delete();
    repeat (2) @(negedge clk);
    viol0 = stable_viol;
    n = $urandom_range(8, 12);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      w = 8'($urandom);
      inData = w;
      inValid = 1'b1;
      exp_q.push_back(w);
      @(negedge clk);
      inValid = 1'b0;
      $display("push %h", w);
    end
    wait_frames(n, ok);
    repeat (150) @(negedge clk);
    checks++; if (!ok || frames.size() != n) begin errors++; $display("FAIL rand_frames: got %0d expected %0d", frames.size(), n); end
    for (int i = 0; i < frames.size() && i < n; i++) begin
      checks++; if (frames[i] !== exp_q[i]) begin errors++; $display("FAIL rand_word%0d: got %h expected %h", i, frames[i], exp_q[i]); end
      $display("frame %h sent", frames[i]);
    end
    checks++; if (stable_viol != viol0) begin errors++; $display("FAIL rand_stable: got %0d changes expected 0", stable_viol - viol0); end
    checks++; if (overflow !== 1'b0 || count !== '0) begin errors++; $display("FAIL rand_end: got ovf=%b count=%0d expected 0/0", overflow, count); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] w;
    int occ;
    bit ok;
    stall = 1'b1;
    do_reset();
    frames.delete();
    repeat (4) @(negedge clk);
    occ = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      w = 8'($urandom);
      inData = w;
      inValid = 1'b1;
      checks++; if (inReady !== (occ != DEPTH)) begin errors++; $display("FAIL ovf_inReady%0d: got %b expected %b", i, inReady, occ != DEPTH); end
      if (occ == DEPTH) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", overflow); end
      end else begin
        exp_q.push_back(w);
        occ++;
      end
      @(negedge clk);
      $display("push %h", w);
      checks++; if (int'(count) != occ) begin errors++; $display("FAIL ovf_count%0d: got %0d expected %0d", i, count, occ); end
    end
    inValid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    stall = 1'b0;
    wait_frames(DEPTH, ok);
    repeat (150) @(negedge clk);
    checks++; if (!ok || frames.size() != DEPTH) begin errors++; $display("FAIL ovf_frames: got %0d expected %0d", frames.size(), DEPTH); end
    for (int i = 0; i < frames.size() && i < DEPTH; i++) begin
      checks++; if (frames[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_word%0d: got %h expected %h", i, frames[i], exp_q[i]); end
      $display("frame %h sent", frames[i]);
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b expected 1", overflow); end
  endtask

  task automatic test_push_pop();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] w;
    bit ok;
    stall = 1'b1;
    do_reset();
    frames.delete();
    repeat (4) @(negedge clk);
    for (int i = 0; i < DEPTH-1; i++) begin
      w = 8'($urandom);
      inData = w;
      inValid = 1'b1;
      exp_q.push_back(w);
      @(negedge clk);
      $display("push %h", w);
    end
    inValid = 1'b0;
    stall = 1'b0;
    // Idle passes two sync flops, then one IDLE->LOAD cycle; the pop edge is the next one.
    repeat (3) @(negedge clk);
    checks++; if (int'(count) != DEPTH-1 || inReady !== 1'b1) begin errors++; $display("FAIL pp_before: got count=%0d ready=%b expected %0d/1", count, inReady, DEPTH-1); end
    w = 8'($urandom);
    inData = w;
    inValid = 1'b1;
    exp_q.push_back(w);
    @(negedge clk);
    inValid = 1'b0;
    $display("push %h", w);
    checks++; if (int'(count) != DEPTH-1) begin errors++; $display("FAIL pp_count: got %0d expected %0d", count, DEPTH-1); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow: got %b expected 0", overflow); end
    wait_frames(DEPTH, ok);
    repeat (150) @(negedge clk);
    checks++; if (!ok || frames.size() != DEPTH) begin errors++; $display("FAIL pp_frames: got %0d expected %0d", frames.size(), DEPTH); end
    for (int i = 0; i < frames.size() && i < DEPTH; i++) begin
      checks++; if (frames[i] !== exp_q[i]) begin errors++; $display("FAIL pp_word%0d: got %h expected %h", i, frames[i], exp_q[i]); end
      $display("frame %h sent", frames[i]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int nf;
    int ns;
    bit ok;
    do_reset();
    frames.delete();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      inData = 8'(8'h70 + i);
      inValid = 1'b1;
      @(negedge clk);
      $display("push %h", 8'(8'h70 + i));
    end
    inValid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tx_busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL mid_no_frame: got busy=%b expected 1", tx_busy); end
    repeat (4) @(negedge clk);
    checks++; if (int'(count) != 2 || txStart !== 1'b0) begin errors++; $display("FAIL mid_busy_state: got count=%0d txStart=%b expected 2/0", count, txStart); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (txStart !== 1'b0 || count !== '0) begin errors++; $display("FAIL mid_reset: got txStart=%b count=%0d expected 0/0", txStart, count); end
    rst_n = 1'b1;
    nf = frames.size();
    ns = start_cycles;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!tx_busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (100) @(negedge clk);
    checks++; if (!ok || frames.size() != nf || start_cycles != ns) begin errors++; $display("FAIL mid_spurious: got frames=%0d starts=%0d expected %0d/%0d", frames.size(), start_cycles, nf, ns); end
    inData = 8'h5A;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    $display("push 5a");
    wait_frames(nf + 1, ok);
    repeat (150) @(negedge clk);
    checks++; if (!ok || frames.size() != nf + 1 || frames[frames.size()-1] !== 8'h5A) begin errors++; $display("FAIL mid_resume: got %0d frames last=%h expected %0d/5a", frames.size(), (frames.size() > 0) ? frames[frames.size()-1] : 8'h00, nf + 1); end
    $display("frame 5a sent after reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_random_stream();
    test_overflow();
    test_push_pop();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
